// File: rtl/frame_seq_pkg.sv
// Shared encodings and the skid-FIFO entry type for the frame op sequencer and its pixel ALU.
package frame_seq_pkg;
  localparam int COORD_W = 11;
  localparam int PIX_W   = 24;

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_BRIGHT = 2'd1;
  localparam logic [1:0] MODE_GRAY   = 2'd2;
  localparam logic [1:0] MODE_ROT    = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic [PIX_W-1:0]   rgb;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic               last;
  } pix_t;

  function automatic logic dims_ok(input int unsigned w, input int unsigned h,
                                   input int unsigned max_dim);
    return (w != 0) && (h != 0) && (w <= max_dim) && (h <= max_dim);
  endfunction
endpackage

// File: rtl/pixel_op_alu.sv
// Combinational per-pixel op: pass, clamped brightness offset, or grayscale average.
// Zero latency, no state; rotate leaves colour untouched.
module pixel_op_alu
  import frame_seq_pkg::*;
(
  input  logic [1:0]       mode,
  input  logic [7:0]       value,
  input  logic             sign,
  input  logic [PIX_W-1:0] pix,
  output logic [PIX_W-1:0] res
);
  function automatic logic [7:0] adjust(input logic [7:0] c, input logic [7:0] v,
                                        input logic add);
    logic [8:0] sum;
    sum = {1'b0, c} + {1'b0, v};
    if (add) return sum[8] ? 8'hff : sum[7:0];
    return (c >= v) ? c - v : 8'h00;
  endfunction

  logic [9:0] sum3;
  logic [7:0] gray;

  always_comb begin
    sum3 = 10'(pix[23:16]) + 10'(pix[15:8]) + 10'(pix[7:0]);
    gray = 8'(sum3 / 10'd3);
    res  = pix;
    case (mode)
      MODE_BRIGHT: res = {adjust(pix[23:16], value, sign),
                          adjust(pix[15:8],  value, sign),
                          adjust(pix[7:0],   value, sign)};
      MODE_GRAY:   res = {3{gray}};
      MODE_PASS, MODE_ROT: res = pix;
      default:     res = pix;
    endcase
  end
endmodule

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush (DEPTH a power of two >= 2); head visible with zero latency.
// Push while full is dropped unless a pop frees the slot in the same cycle; the caller owns flow control.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               pop_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/frame_op_sequencer.sv
// Frame walker: raster reads, pixel ALU, 2-deep skid FIFO; first out_valid two edges after the start edge.
// Reads are credit-throttled so out_ready backpressure never overflows the FIFO. Mode 3 needs FRAME_SEQ_ROTATE_EN.
module frame_op_sequencer
  import frame_seq_pkg::*;
#(
  parameter int MAX_DIM = 2047,
  parameter int ADDR_W  = 22
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         cfg_mode,
  input  logic [7:0]         cfg_value,
  input  logic               cfg_sign,
  input  logic [COORD_W-1:0] cfg_width,
  input  logic [COORD_W-1:0] cfg_height,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_raddr,
  input  logic [PIX_W-1:0]   mem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W-1:0]   out_rgb,
  output logic [COORD_W-1:0] out_row,
  output logic [COORD_W-1:0] out_col,
  output logic               out_last,
  output logic [31:0]        out_width,
  output logic [31:0]        out_height,
  output logic               busy,
  output logic               frame_done,
  output logic               cfg_err
);
  logic [1:0]         state;
  logic [1:0]         mode_q;
  logic [7:0]         value_q;
  logic               sign_q;
  logic [COORD_W-1:0] width_q, height_q, dst_w, dst_h;
  logic [COORD_W-1:0] row, col, rd_row, rd_col;
  logic [ADDR_W-1:0]  addr;
  logic               rd_pending, rd_last;
  logic [1:0]         fifo_count;
  logic [PIX_W-1:0]   alu_rgb;
  pix_t               push_dat, head;
  logic               handshake, issue, last_issue, mode_ok, cfg_ok;

  assign handshake  = out_valid && out_ready;
  assign last_issue = (row == height_q - COORD_W'(1)) && (col == width_q - COORD_W'(1));
  // A read is allowed when the FIFO can still hold it after this cycle's pop, keeping 1 pixel/cycle.
  assign issue = (state == ST_RUN) &&
                 (({1'b0, rd_pending} + fifo_count) < (2'd2 + {1'b0, handshake}));

`ifdef FRAME_SEQ_ROTATE_EN
  assign mode_ok = 1'b1;
`else
  assign mode_ok = (cfg_mode != MODE_ROT);
`endif
  assign cfg_ok = mode_ok && dims_ok(32'(cfg_width), 32'(cfg_height), MAX_DIM);

  pixel_op_alu u_alu (
    .mode  (mode_q),
    .value (value_q),
    .sign  (sign_q),
    .pix   (mem_rdata),
    .res   (alu_rgb)
  );

  always_comb begin
    push_dat = '{rgb: alu_rgb, row: rd_row, col: rd_col, last: rd_last};
`ifdef FRAME_SEQ_ROTATE_EN
    if (mode_q == MODE_ROT) begin
      push_dat.row = rd_col;
      push_dat.col = height_q - COORD_W'(1) - rd_row;
    end
`endif
  end

  sync_fifo #(.W($bits(pix_t)), .DEPTH(2)) u_skid (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .flush    (abort),
    .push     (rd_pending),
    .push_dat (push_dat),
    .pop      (handshake),
    .pop_dat  (head),
    .count    (fifo_count)
  );

  assign out_valid  = (fifo_count != 2'd0);
  assign out_rgb    = head.rgb;
  assign out_row    = head.row;
  assign out_col    = head.col;
  assign out_last   = head.last;
  assign out_width  = 32'(dst_w);
  assign out_height = 32'(dst_h);
  assign busy       = (state != ST_IDLE);
  assign mem_rd_en  = issue;
  assign mem_raddr  = addr;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state      <= ST_IDLE;
      mode_q     <= '0;
      value_q    <= '0;
      sign_q     <= 1'b0;
      width_q    <= '0;
      height_q   <= '0;
      dst_w      <= '0;
      dst_h      <= '0;
      row        <= '0;
      col        <= '0;
      addr       <= '0;
      rd_pending <= 1'b0;
      rd_row     <= '0;
      rd_col     <= '0;
      rd_last    <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      rd_pending <= issue && !abort;
      if (issue) begin
        rd_row  <= row;
        rd_col  <= col;
        rd_last <= last_issue;
        addr    <= addr + ADDR_W'(1);
        if (col == width_q - COORD_W'(1)) begin
          col <= '0;
          row <= row + COORD_W'(1);
        end else begin
          col <= col + COORD_W'(1);
        end
      end
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (start) begin
            if (cfg_ok) begin
              mode_q   <= cfg_mode;
              value_q  <= cfg_value;
              sign_q   <= cfg_sign;
              width_q  <= cfg_width;
              height_q <= cfg_height;
`ifdef FRAME_SEQ_ROTATE_EN
              dst_w    <= (cfg_mode == MODE_ROT) ? cfg_height : cfg_width;
              dst_h    <= (cfg_mode == MODE_ROT) ? cfg_width : cfg_height;
`else
              dst_w    <= cfg_width;
              dst_h    <= cfg_height;
`endif
              row      <= '0;
              col      <= '0;
              addr     <= '0;
              state    <= ST_RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
          ST_RUN:   if (issue && last_issue) state <= ST_DRAIN;
          ST_DRAIN: if (handshake && head.last) begin
            state      <= ST_IDLE;
            frame_done <= 1'b1;
          end
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_frame_op_sequencer.sv
// Randomized bench for frame_op_sequencer: a queue-based frame model predicts every output pixel.
`timescale 1ns/1ps
module tb_frame_op_sequencer;
  logic        HCLK = 1'b0;
  logic        HRESETn, start, abort, cfg_sign, out_ready;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_value;
  logic [10:0] cfg_width, cfg_height, out_row, out_col;
  logic        mem_rd_en, out_valid, out_last, busy, frame_done, cfg_err;
  logic [21:0] mem_raddr;
  logic [23:0] mem_rdata, out_rgb;
  logic [31:0] out_width, out_height;

  always #5 HCLK = ~HCLK;

  frame_op_sequencer dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .abort(abort),
    .cfg_mode(cfg_mode), .cfg_value(cfg_value), .cfg_sign(cfg_sign),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .mem_rd_en(mem_rd_en), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rgb(out_rgb),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .out_width(out_width), .out_height(out_height),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  typedef struct { logic [23:0] rgb; int row; int col; bit last; } exp_t;
  exp_t        exp_q[$];
  exp_t        e;
  logic [23:0] got_q[$];
  logic [21:0] got_rc_q[$];
  logic [23:0] mem_model [4096];
  int          checks = 0, errors = 0;
  int          hs_cnt = 0, done_cnt = 0, exp_w = 0, exp_h = 0, ready_mode = 3;
  bit          pend_done = 0, prev_stall = 0;
  logic [46:0] prev_out;
`ifdef FRAME_SEQ_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  // Frame memory: data returned one cycle after the read address.
  always @(posedge HCLK) mem_rdata <= mem_model[mem_raddr[11:0]];

  always @(posedge HCLK) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      2:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  function automatic logic [23:0] ref_pix(input int mode, input int v, input bit add,
                                          input logic [23:0] p);
    int ch[3];
    int r;
    ch[0] = int'(p[23:16]);
    ch[1] = int'(p[15:8]);
    ch[2] = int'(p[7:0]);
    if (mode == 1) begin
      for (int i = 0; i < 3; i++) begin
        r = add ? ch[i] + v : ch[i] - v;
        if (r > 255) r = 255;
        if (r < 0) r = 0;
        ch[i] = r;
      end
    end else if (mode == 2) begin
      r = (ch[0] + ch[1] + ch[2]) / 3;
      ch[0] = r; ch[1] = r; ch[2] = r;
    end
    return {8'(ch[0]), 8'(ch[1]), 8'(ch[2])};
  endfunction

  function automatic logic [23:0] got_at(input int i);
    return (got_q.size() > i) ? got_q[i] : 24'hbad0bd;
  endfunction

  // Output monitor, sampled on the falling edge.
  always @(negedge HCLK) begin
    if (HRESETn && !abort) begin
      check_eq("done_pulse", frame_done, pend_done);
      if (pend_done) begin
        check_eq("busy_after_done", busy, 1'b0);
        done_cnt++;
        pend_done = 0;
      end
      if (prev_stall)
        check_eq("hold", {out_valid, out_rgb, out_row, out_col, out_last}, {1'b1, prev_out});
      if (out_valid && out_ready) begin
        hs_cnt++;
        got_q.push_back(out_rgb);
        got_rc_q.push_back({out_row, out_col});
        if (exp_q.size() == 0) begin
          check_eq("extra_pixel", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check_eq("rgb", out_rgb, e.rgb);
          check_eq("row", out_row, e.row);
          check_eq("col", out_col, e.col);
          check_eq("last", out_last, e.last);
          check_eq("width", out_width, exp_w);
          check_eq("height", out_height, exp_h);
          if (e.last) pend_done = 1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_rgb, out_row, out_col, out_last};
    end else begin
      pend_done  = 0;
      prev_stall = 0;
    end
  end

  task automatic start_frame(input int mode, input int v, input bit add,
                             input int w, input int h, input bit expect_ok);
    exp_t x;
    cfg_mode = 2'(mode); cfg_value = 8'(v); cfg_sign = add;
    cfg_width = 11'(w); cfg_height = 11'(h);
    if (expect_ok) begin
      exp_q.delete(); got_q.delete(); got_rc_q.delete(); hs_cnt = 0;
      exp_w = (mode == 3) ? h : w;
      exp_h = (mode == 3) ? w : h;
      for (int r = 0; r < h; r++)
        for (int c = 0; c < w; c++) begin
          x.rgb  = ref_pix(mode, v, add, mem_model[r * w + c]);
          x.row  = (mode == 3) ? c : r;
          x.col  = (mode == 3) ? h - 1 - r : c;
          x.last = (r == h - 1) && (c == w - 1);
          exp_q.push_back(x);
        end
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    check_eq("cfg_err", cfg_err, !expect_ok);
    check_eq("busy_start", busy, expect_ok);
  endtask

  task automatic wait_frame(input int w, input int h);
    int target = done_cnt + 1;
    int n = 0;
    while (done_cnt < target && n < 4 * w * h + 50) begin
      tick;
      n++;
    end
    check_eq("frame_done_seen", done_cnt, target);
    check_eq("handshakes", hs_cnt, w * h);
    check_eq("exp_drained", exp_q.size(), 0);
    if (done_cnt < target) begin
      abort = 1'b1;
      tick;
      abort = 1'b0;
      exp_q.delete();
    end
    tick;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n, w, h, m, saved;
    logic [23:0] px;
    logic [21:0] rc;
    HRESETn = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    cfg_mode = '0; cfg_value = '0; cfg_sign = 1'b0; cfg_width = '0; cfg_height = '0;
    for (int i = 0; i < 4096; i++) mem_model[i] = 24'($urandom);
    repeat (3) tick;
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_rd_en", mem_rd_en, 1'b0);
    check_eq("rst_raddr", mem_raddr, 22'd0);
    check_eq("rst_done", frame_done, 1'b0);
    check_eq("rst_err", cfg_err, 1'b0);
    check_eq("rst_rgb", out_rgb, 24'd0);
    check_eq("rst_width", out_width, 32'd0);
    HRESETn = 1'b1;
    tick;
    ready_mode = 0;

    // Brightness add with saturation, 4x2, plus start-to-first-valid latency.
    mem_model[0] = {8'd200, 8'd7, 8'd9};
    mem_model[1] = {8'd50, 8'd250, 8'd0};
    start_frame(1, 100, 1'b1, 4, 2, 1'b1);
    n = 0;
    while (!out_valid && n < 10) begin
      tick;
      n++;
    end
    check_eq("first_valid_lat", n, 2);
    wait_frame(4, 2);
    px = got_at(0); check_eq("bright_sat", px[23:16], 8'd255);
    px = got_at(1); check_eq("bright_add", px[23:16], 8'd150);

    // Brightness subtract with floor, 3x1.
    mem_model[0] = {8'd1, 8'd30, 8'd2};
    mem_model[1] = {8'd3, 8'd130, 8'd4};
    start_frame(1, 100, 1'b0, 3, 1, 1'b1);
    wait_frame(3, 1);
    px = got_at(0); check_eq("bright_floor", px[15:8], 8'd0);
    px = got_at(1); check_eq("bright_sub", px[15:8], 8'd30);

    // Grayscale truncating average.
    mem_model[0] = {8'd10, 8'd20, 8'd31};
    start_frame(2, 0, 1'b0, 1, 1, 1'b1);
    wait_frame(1, 1);
    check_eq("gray", got_at(0), 24'h141414);

    // 16x16 with out_ready toggling every cycle.
    ready_mode = 1;
    start_frame(1, 37, 1'b1, 16, 16, 1'b1);
    wait_frame(16, 16);
    ready_mode = 0;

    // Rotate, or its rejection when not built.
    if (ROT_EN) begin
      start_frame(3, 0, 1'b0, 4, 2, 1'b1);
      wait_frame(4, 2);
      rc = (got_rc_q.size() > 3) ? got_rc_q[3] : 22'h3fffff;
      check_eq("rot_coord", rc, {11'd3, 11'd1});
      check_eq("rot_out_width", out_width, 32'd2);
      check_eq("rot_out_height", out_height, 32'd4);
    end else begin
      start_frame(3, 0, 1'b0, 4, 2, 1'b0);
    end

    // Zero width rejected.
    start_frame(0, 0, 1'b0, 0, 5, 1'b0);

    // start while busy is ignored, even with a bad config on the bus.
    start_frame(0, 0, 1'b0, 8, 8, 1'b1);
    repeat (3) tick;
    cfg_width = 11'd0;
    start = 1'b1;
    tick;
    start = 1'b0;
    check_eq("start_busy_no_err", cfg_err, 1'b0);
    check_eq("start_busy_still_busy", busy, 1'b1);
    wait_frame(8, 8);

    // Abort after the fifth handshake.
    start_frame(1, 20, 1'b0, 6, 4, 1'b1);
    n = 0;
    while (hs_cnt < 5 && n < 100) begin
      tick;
      n++;
    end
    check_eq("abort_reach_px5", hs_cnt, 5);
    saved = done_cnt;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    exp_q.delete();
    check_eq("abort_valid", out_valid, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_rd_en", mem_rd_en, 1'b0);
    repeat (6) tick;
    check_eq("abort_no_done", done_cnt, saved);

    // Random frames with random backpressure.
    ready_mode = 2;
    for (int k = 0; k < 8; k++) begin
      w = $urandom_range(1, 20);
      h = $urandom_range(1, 12);
      m = ROT_EN ? $urandom_range(0, 3) : $urandom_range(0, 2);
      start_frame(m, $urandom_range(0, 255), 1'($urandom), w, h, 1'b1);
      wait_frame(w, h);
    end
    ready_mode = 0;

    // Synchronous reset mid-frame clears every output.
    start_frame(0, 0, 1'b0, 10, 10, 1'b1);
    repeat (7) tick;
    HRESETn = 1'b0;
    tick;
    check_eq("mrst_valid", out_valid, 1'b0);
    check_eq("mrst_busy", busy, 1'b0);
    check_eq("mrst_rd_en", mem_rd_en, 1'b0);
    check_eq("mrst_raddr", mem_raddr, 22'd0);
    check_eq("mrst_rgb", out_rgb, 24'd0);
    check_eq("mrst_rowcol", {out_row, out_col, out_last}, 23'd0);
    check_eq("mrst_dims", {out_width, out_height}, 64'd0);
    check_eq("mrst_pulses", {frame_done, cfg_err}, 2'b00);
    HRESETn = 1'b1;
    exp_q.delete();
    tick;
    start_frame(2, 0, 1'b0, 3, 3, 1'b1);
    wait_frame(3, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
